// File: rtl/polaris_bus_arbiter.sv
// polaris_bus_arbiter: lets the Polaris CPU instruction (I) and data (D)
// masters share one 64-bit memory bus.
// The grant is registered. On a tie, the master that was not granted last
// wins. The bus and the acknowledges are combinational from the grant
// state. A stall watchdog turns a hung slave into a synthetic ack plus an
// error pulse.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; the shared bus is parked at all zeros
// IGNT  | I master owns the bus until an ack (real or synthetic)
// DGNT  | D master owns the bus for as long as dcyc_i is held
module polaris_bus_arbiter #(
  parameter int TMO_EN = 1,
  parameter int TMO_W  = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // instruction master
  input  logic [63:0] iadr_i,
  input  logic [1:0]  isiz_i,
  output logic        iack_o,
  output logic [31:0] idat_o,
  // data master
  input  logic [63:0] dadr_i,
  input  logic [63:0] ddat_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  output logic        dack_o,
  output logic [63:0] ddat_o,
  // shared bus
  output logic [63:0] madr_o,
  output logic [63:0] mdat_o,
  output logic        mwe_o,
  output logic        mcyc_o,
  output logic        mstb_o,
  output logic        msigned_o,
  output logic [1:0]  msiz_o,
  input  logic [63:0] mdat_i,
  input  logic        mack_i,
  // diagnostics
  output logic        err_o,
  output logic [1:0]  gnt_o
);

  // The encoding doubles as the gnt_o diagnostic value.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] IGNT = 2'b01;
  localparam logic [1:0] DGNT = 2'b10;

  localparam logic [TMO_W-1:0] CNT_MAX = {TMO_W{1'b1}};

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             last_i;
  logic             arb;
  logic             ireq;
  logic             dreq;
  logic             bus_stb;
  logic             stall;
  logic             tmo;
  logic [TMO_W-1:0] tmo_cnt;

  assign ireq = |isiz_i;
  assign dreq = dcyc_i;

  // The strobe is computed on its own so the watchdog does not loop
  // through the output process. I always strobes once granted. D strobes
  // with dstb_i.
  assign bus_stb = (state == IGNT) | ((state == DGNT) & dstb_i);
  assign stall   = bus_stb & ~mack_i;
  assign tmo     = (TMO_EN != 0) && stall && (tmo_cnt == CNT_MAX);

  // State register and tie-break history.
  // last_i resets to 1, as if I had been granted last, so D wins the first
  // tie after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      last_i <= 1'b1;
    end else begin
      state <= next_state;
      if (arb && (next_state != IDLE))
        last_i <= (next_state == IGNT);
    end
  end

  // Next-state logic.
  // Arbitration happens in IDLE and at the edge that ends a grant, so
  // back-to-back grants need no idle bubble.
  always_comb begin
    next_state = state;
    arb        = 1'b0;
    case (state)
      IDLE:    arb = 1'b1;
      IGNT:    arb = mack_i | tmo;
      DGNT:    arb = ~dcyc_i;
      default: arb = 1'b1;
    endcase
    if (arb) begin
      if (ireq && dreq)
        next_state = last_i ? DGNT : IGNT;
      else if (ireq)
        next_state = IGNT;
      else if (dreq)
        next_state = DGNT;
      else
        next_state = IDLE;
    end
  end

  // Stall watchdog counter.
  // It counts strobed cycles that get no ack. It restarts on any ack, on
  // any grant boundary and while idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt <= '0;
    end else if ((TMO_EN == 0) || (state == IDLE) || mack_i || tmo ||
                 arb || (next_state != state)) begin
      tmo_cnt <= '0;
    end else if (stall) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Output logic.
  // Steers the granted master onto the shared bus and gates the acks by
  // grant. During a timeout the read data is forced to zero so the master
  // never latches stale bus contents.
  always_comb begin
    madr_o    = '0;
    mdat_o    = '0;
    mwe_o     = 1'b0;
    mcyc_o    = 1'b0;
    mstb_o    = 1'b0;
    msigned_o = 1'b0;
    msiz_o    = '0;
    iack_o    = 1'b0;
    dack_o    = 1'b0;
    case (state)
      IGNT: begin
        madr_o = iadr_i;
        msiz_o = isiz_i;
        mcyc_o = 1'b1;
        mstb_o = bus_stb;
        iack_o = mack_i | tmo;
      end
      DGNT: begin
        madr_o    = dadr_i;
        mdat_o    = ddat_i;
        mwe_o     = dwe_i;
        mcyc_o    = dcyc_i;
        mstb_o    = bus_stb;
        msigned_o = dsigned_i;
        msiz_o    = dsiz_i;
        dack_o    = mack_i | tmo;
      end
      default: ;
    endcase
  end

  // Read data return path.
  // The I lane is chosen by address bit 2. Both return buses are held at
  // zero during a timeout and during reset.
  always_comb begin
    idat_o = '0;
    ddat_o = '0;
    if (!reset_i && !tmo) begin
      idat_o = iadr_i[2] ? mdat_i[63:32] : mdat_i[31:0];
      ddat_o = mdat_i;
    end
  end

  assign err_o = tmo;
  assign gnt_o = state;

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Directed bench for polaris_bus_arbiter.
// The stimulus pushes the expected acks into a queue. A monitor pops the
// queue and compares whenever the DUT presents an ack.
module tb_polaris_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] iadr;
  logic [1:0]  isiz;
  logic [63:0] dadr;
  logic [63:0] ddat;
  logic        dwe;
  logic        dcyc;
  logic        dstb;
  logic [1:0]  dsiz;
  logic        dsigned;
  logic [63:0] mdat;
  logic        mack;

  logic        iack_o;
  logic [31:0] idat_o;
  logic        dack_o;
  logic [63:0] ddat_o;
  logic [63:0] madr_o;
  logic [63:0] mdat_o;
  logic        mwe_o;
  logic        mcyc_o;
  logic        mstb_o;
  logic        msigned_o;
  logic [1:0]  msiz_o;
  logic        err_o;
  logic [1:0]  gnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  polaris_bus_arbiter #(.TMO_EN(1), .TMO_W(4)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .iadr_i    (iadr),
    .isiz_i    (isiz),
    .iack_o    (iack_o),
    .idat_o    (idat_o),
    .dadr_i    (dadr),
    .ddat_i    (ddat),
    .dwe_i     (dwe),
    .dcyc_i    (dcyc),
    .dstb_i    (dstb),
    .dsiz_i    (dsiz),
    .dsigned_i (dsigned),
    .dack_o    (dack_o),
    .ddat_o    (ddat_o),
    .madr_o    (madr_o),
    .mdat_o    (mdat_o),
    .mwe_o     (mwe_o),
    .mcyc_o    (mcyc_o),
    .mstb_o    (mstb_o),
    .msigned_o (msigned_o),
    .msiz_o    (msiz_o),
    .mdat_i    (mdat),
    .mack_i    (mack),
    .err_o     (err_o),
    .gnt_o     (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic exp_ack(input bit is_d, input logic [63:0] data, input logic err);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (!reset_i && (iack_o || dack_o)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack iack=%0b dack=%0b err=%0b required no ack", iack_o, dack_o, err_o);
      end else begin
        exp_t e;
        logic [63:0] got;
        e = exp_q.pop_front();
        got = e.is_d ? ddat_o : {32'h0, idat_o};
        if ((iack_o !== !e.is_d) || (dack_o !== e.is_d) || (got !== e.data) || (err_o !== e.err)) begin
          errors++;
          $display("FAIL ack_%s got iack=%0b dack=%0b data=%h err=%0b required iack=%0b dack=%0b data=%h err=%0b",
                   e.is_d ? "d" : "i", iack_o, dack_o, got, err_o, !e.is_d, e.is_d, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL tb_timeout got=stuck required=finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    iadr = '0; isiz = '0; dadr = '0; ddat = '0; dwe = 1'b0;
    dcyc = 1'b0; dstb = 1'b0; dsiz = '0; dsigned = 1'b0;
    mdat = '0; mack = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_mcyc", mcyc_o, 0);
    chk("rst_err", err_o, 0);
    reset_i = 1'b0;

    // I-only fetch, acked on the third granted cycle
    step();
    iadr = 64'h1004; isiz = 2'd2;
    step(); #1;
    chk("i_gnt", gnt_o, 1);
    chk("i_madr", madr_o, 64'h1004);
    chk("i_mstb", mstb_o, 1);
    step();
    step();
    mdat = 64'hAAAA_BBBB_CCCC_DDDD; mack = 1'b1; isiz = 2'd0;
    exp_ack(0, 64'hAAAA_BBBB, 0);
    step();
    mack = 1'b0; #1;
    chk("i_done_idle", gnt_o, 0);

    // tie from reset: D first, then I, then D again
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    iadr = 64'h2000; isiz = 2'd1;
    dcyc = 1'b1; dstb = 1'b1; dadr = 64'h3000; dwe = 1'b0; dsiz = 2'd3; dsigned = 1'b1;
    step(); #1;
    chk("tie1_d", gnt_o, 2);
    chk("tie1_madr", madr_o, 64'h3000);
    chk("tie1_msigned", msigned_o, 1);
    step();
    mdat = 64'h1111_2222_3333_4444; mack = 1'b1;
    exp_ack(1, 64'h1111_2222_3333_4444, 0);
    step();
    mack = 1'b0; dcyc = 1'b0; dstb = 1'b0; #1;
    chk("d_end_hold", gnt_o, 2);
    step(); #1;
    chk("tie1_i_next", gnt_o, 1);
    chk("tie1_i_madr", madr_o, 64'h2000);
    dcyc = 1'b1; dstb = 1'b1;
    mdat = 64'h5555_6666_7777_8888; mack = 1'b1;
    exp_ack(0, 64'h7777_8888, 0);
    step();
    mack = 1'b0; #1;
    chk("tie2_d", gnt_o, 2);
    step();
    mdat = 64'h0123_4567_89AB_CDEF; mack = 1'b1;
    exp_ack(1, 64'h0123_4567_89AB_CDEF, 0);
    step();
    mack = 1'b0; dcyc = 1'b0; dstb = 1'b0;
    step(); #1;
    chk("tie2_i_pending", gnt_o, 1);
    mdat = 64'hDEAD_BEEF_CAFE_F00D; mack = 1'b1; isiz = 2'd0;
    exp_ack(0, 64'hCAFE_F00D, 0);
    step();
    mack = 1'b0; #1;
    chk("tie2_idle", gnt_o, 0);

    // D lock: three acked beats while I keeps requesting
    iadr = 64'h4004; isiz = 2'd2;
    dcyc = 1'b1; dstb = 1'b1; dwe = 1'b1; dsigned = 1'b0;
    ddat = 64'hFEED_FACE_0BAD_F00D; dadr = 64'h5000;
    step(); #1;
    chk("lock_gnt0", gnt_o, 2);
    chk("lock_mwe", mwe_o, 1);
    chk("lock_mdat", mdat_o, 64'hFEED_FACE_0BAD_F00D);
    for (int b = 0; b < 3; b++) begin
      mack = 1'b1;
      mdat = 64'hB0B0_0000_0000_0000 | 64'(b);
      exp_ack(1, 64'hB0B0_0000_0000_0000 | 64'(b), 0);
      #1;
      chk("lock_gnt", gnt_o, 2);
      step();
    end
    mack = 1'b0; dcyc = 1'b0; dstb = 1'b0; dwe = 1'b0; #1;
    chk("lock_end_hold", gnt_o, 2);
    step(); #1;
    chk("lock_i_next", gnt_o, 1);
    mdat = 64'h9999_8888_7777_6666; mack = 1'b1; isiz = 2'd0;
    exp_ack(0, 64'h9999_8888, 0);
    step();
    mack = 1'b0; #1;
    chk("lock_idle", gnt_o, 0);

    // watchdog: I grant with the slave stuck, fires on stalled cycle 16
    iadr = 64'h6004; isiz = 2'd3; mdat = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_ack(0, 64'h0, 1);
    step(); #1;
    chk("wd_gnt", gnt_o, 1);
    for (int c = 2; c <= 15; c++) step();
    #1;
    chk("wd_err_c15", err_o, 0);
    chk("wd_iack_c15", iack_o, 0);
    step();
    isiz = 2'd0; #1;
    chk("wd_err_c16", err_o, 1);
    step(); #1;
    chk("wd_idle", gnt_o, 0);
    chk("wd_err_clear", err_o, 0);
    mdat = '0;

    // asynchronous reset in the middle of a D grant
    dcyc = 1'b1; dstb = 1'b1; dadr = 64'h7000;
    step(); #1;
    chk("rstd_gnt", gnt_o, 2);
    chk("rstd_mstb", mstb_o, 1);
    #1 reset_i = 1'b1;
    #1;
    chk("rstd_async_mcyc", mcyc_o, 0);
    chk("rstd_async_mstb", mstb_o, 0);
    chk("rstd_async_gnt", gnt_o, 0);
    step();
    reset_i = 1'b0;
    iadr = 64'h8000; isiz = 2'd1;
    step(); #1;
    chk("rstd_tie_d", gnt_o, 2);

    // D abort with no ack hands the bus to the pending I
    dcyc = 1'b0; dstb = 1'b0; #1;
    chk("abort_dack", dack_o, 0);
    chk("abort_hold", gnt_o, 2);
    step(); #1;
    chk("abort_i_next", gnt_o, 1);
    mdat = 64'h0F0F_0F0F_1234_5678; mack = 1'b1; isiz = 2'd0;
    exp_ack(0, 64'h1234_5678, 0);
    step();
    mack = 1'b0; #1;
    chk("abort_idle", gnt_o, 0);

    step();
    step();
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
